// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: size codes, FSM states
// and byte-lane mask helpers.
package sram_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR, WR_HOLD, DONE
  } state_e;

  // bit i set = byte lane i (sram_data[8i+7:8i]) selected
  typedef logic [3:0] lane_mask_t;

  function automatic lane_mask_t lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: lane_mask = lane_mask_t'(4'b0001 << addr_lo);
      SZ_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sram_lane_align.sv
// Byte-lane steering: active-low byte enables, write-data replication and
// read-data right-alignment from the latched size and low address bits.
module sram_lane_align
  import sram_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] sram_rd,
  output logic [3:0]  be_l,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_shift
);

  logic [31:0] sh;

  always_comb begin
    be_l        = ~lane_mask(size, addr_lo);
    wdata_rep   = wdata;
    rdata_shift = '0;
    sh          = '0;
    case (size)
      SZ_BYTE: begin
        wdata_rep   = {4{wdata[7:0]}};
        sh          = sram_rd >> {addr_lo, 3'b000};
        rdata_shift = {24'h0, sh[7:0]};
      end
      SZ_HALF: begin
        wdata_rep   = {2{wdata[15:0]}};
        sh          = sram_rd >> {addr_lo[1], 4'b0000};
        rdata_shift = {16'h0, sh[15:0]};
      end
      SZ_WORD: begin
        rdata_shift = sram_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter in front of a 2x16-bit asynchronous SRAM pair.
// Define SRAM_ARB_MISALIGN_CHK_EN to reject misaligned half/word accesses.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [19:0] m0_addr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [19:0] m1_addr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [17:0] sram_addr,
  inout  wire  [31:0] sram_data,
  output logic        sram_oe_l,
  output logic        sram_we_l,
  output logic        sram_ce_l,
  output logic [3:0]  sram_be_l
);

  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES - 1);

  state_e      state, state_nxt;
  logic        gnt, last_gnt;
  logic        we_q, err_q;
  logic [1:0]  size_q, alo_q;
  logic [31:0] wdata_q, rdata_q;
  logic [2:0]  cnt;

  logic        any_req, pick;
  logic        sel_we, sel_err;
  logic [19:0] sel_addr;
  logic [1:0]  sel_size;
  logic [31:0] sel_wdata;

  logic        drive, lanes_on;
  logic [3:0]  al_be_l;
  logic [31:0] al_wdata, al_rdata;

  // pick = 1 grants port 1; on a tie the port not granted last wins
  assign any_req   = m0_req | m1_req;
  assign pick      = (m0_req & m1_req) ? ~last_gnt : m1_req;
  assign sel_we    = pick ? m1_we    : m0_we;
  assign sel_addr  = pick ? m1_addr  : m0_addr;
  assign sel_size  = pick ? m1_size  : m0_size;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;

`ifdef SRAM_ARB_MISALIGN_CHK_EN
  assign sel_err = (sel_size == SZ_RSVD) ||
                   ((sel_size == SZ_HALF) && sel_addr[0]) ||
                   ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00));
`else
  assign sel_err = (sel_size == SZ_RSVD);
`endif

  sram_lane_align u_align (
    .size        (size_q),
    .addr_lo     (alo_q),
    .wdata       (wdata_q),
    .sram_rd     (sram_data),
    .be_l        (al_be_l),
    .wdata_rep   (al_wdata),
    .rdata_shift (al_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sram_ce_l = 1'b1;
    sram_oe_l = 1'b1;
    sram_we_l = 1'b1;
    drive     = 1'b0;
    lanes_on  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = sel_err ? DONE : (sel_we ? WR_SETUP : RD);
      end
      RD: begin
        sram_ce_l = 1'b0;
        sram_oe_l = 1'b0;
        lanes_on  = 1'b1;
        if (cnt == 3'd0) state_nxt = DONE;
      end
      WR_SETUP: begin
        sram_ce_l = 1'b0;
        lanes_on  = 1'b1;
        drive     = 1'b1;
        state_nxt = WR;
      end
      WR: begin
        sram_ce_l = 1'b0;
        sram_we_l = 1'b0;
        lanes_on  = 1'b1;
        drive     = 1'b1;
        if (cnt == 3'd0) state_nxt = WR_HOLD;
      end
      WR_HOLD: begin
        sram_ce_l = 1'b0;
        lanes_on  = 1'b1;
        drive     = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // request is latched at grant; port inputs are ignored until back in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= 1'b0;
      last_gnt  <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      alo_q     <= 2'b00;
      wdata_q   <= '0;
      rdata_q   <= '0;
      sram_addr <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gnt       <= pick;
          last_gnt  <= pick;
          we_q      <= sel_we;
          err_q     <= sel_err;
          size_q    <= sel_size;
          alo_q     <= sel_addr[1:0];
          wdata_q   <= sel_wdata;
          sram_addr <= sel_addr[19:2];
          rdata_q   <= '0;
          cnt       <= CNT_INIT;
        end
        RD: begin
          if (cnt == 3'd0) rdata_q <= al_rdata;
          else             cnt     <= cnt - 3'd1;
        end
        WR: if (cnt != 3'd0) cnt <= cnt - 3'd1;
        default: ;
      endcase
    end
  end

  assign sram_data = drive ? al_wdata : 32'hz;
  assign sram_be_l = lanes_on ? al_be_l : 4'hF;
  assign m0_ack    = (state == DONE) & ~gnt;
  assign m1_ack    = (state == DONE) &  gnt;
  assign err       = (state == DONE) & err_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed + randomized bench for sram_arbiter with a byte-addressed
// reference memory and a behavioural SRAM pair on the data bus.
module tb_sram_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [19:0] m0_addr = 0, m1_addr = 0;
  logic [1:0]  m0_size = 0, m1_size = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_ack, m1_ack, err;
  logic [31:0] rdata;
  logic [17:0] sram_addr;
  wire  [31:0] sram_data;
  logic        sram_oe_l, sram_we_l, sram_ce_l;
  logic [3:0]  sram_be_l;

  int n_tests = 0;
  int n_fail  = 0;
  int ref_last = 0;

  logic [31:0] sram_mem [0:255] = '{default: 32'h0};
  logic [31:0] ref_mem  [0:255] = '{default: 32'h0};

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata(rdata), .err(err), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_oe_l(sram_oe_l), .sram_we_l(sram_we_l), .sram_ce_l(sram_ce_l),
    .sram_be_l(sram_be_l)
  );

  always #5 clk = ~clk;

  // SRAM pair: byte-maskable write while we_l low, drive bus while oe_l low
  always @(posedge clk)
    if (!sram_ce_l && !sram_we_l)
      for (int b = 0; b < 4; b++)
        if (!sram_be_l[b]) sram_mem[sram_addr[7:0]][8*b +: 8] <= sram_data[8*b +: 8];

  assign sram_data = (!sram_ce_l && !sram_oe_l) ? sram_mem[sram_addr[7:0]] : 32'hz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [1:0] sz, input logic [1:0] a);
    exp_err = (sz == 2'd3);
`ifdef SRAM_ARB_MISALIGN_CHK_EN
    if (sz == 2'd1 && a[0]) exp_err = 1'b1;
    if (sz == 2'd2 && a != 2'd0) exp_err = 1'b1;
`endif
  endfunction

  // byte offset of the lowest selected lane, and number of bytes moved
  function automatic int lane_off(input logic [1:0] sz, input logic [1:0] a);
    lane_off = (sz == 2'd0) ? int'(a) : (sz == 2'd1) ? 2 * int'(a[1]) : 0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < nbytes(sz); i++) m[lane_off(sz, a) + i] = 1'b1;
    exp_be = ~m;
  endfunction

  function automatic logic [31:0] exp_bus(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % nbytes(sz)) +: 8];
    exp_bus = r;
  endfunction

  task automatic access(input int port, input logic we, input logic [19:0] addr,
                        input logic [1:0] sz, input logic [31:0] wd, input string tag);
    logic        e, got, overlap;
    int          lat, cnt, oe_n, we_n, ce_n;
    logic [3:0]  be_seen;
    logic [31:0] bus, expd, word;
    e   = exp_err(sz, addr[1:0]);
    lat = e ? 2 : (we ? W + 4 : W + 2);
    @(posedge clk); #1;
    if (port == 1) begin m1_we = we; m1_addr = addr; m1_size = sz; m1_wdata = wd; m1_req = 1; end
    else           begin m0_we = we; m0_addr = addr; m0_size = sz; m0_wdata = wd; m0_req = 1; end
    cnt = 0; got = 0; overlap = 0; oe_n = 0; we_n = 0; ce_n = 0; be_seen = 4'hF; bus = 0;
    while (!got && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (!sram_oe_l) oe_n++;
      if (!sram_we_l) begin we_n++; bus = sram_data; end
      if (!sram_ce_l) begin ce_n++; be_seen = sram_be_l; end
      if (!sram_oe_l && !sram_we_l) overlap = 1;
      got = (port == 1) ? m1_ack : m0_ack;
    end
    check({tag, ".ack_seen"}, 32'(got), 32'd1);
    check({tag, ".latency"}, cnt, lat);
    check({tag, ".other_ack"}, 32'((port == 1) ? m0_ack : m1_ack), 32'd0);
    check({tag, ".err"}, 32'(err), 32'(e));
    check({tag, ".oe_we_overlap"}, 32'(overlap), 32'd0);
    check({tag, ".oe_cycles"}, oe_n, (e || we) ? 0 : W);
    check({tag, ".we_cycles"}, we_n, (e || !we) ? 0 : W);
    check({tag, ".ce_cycles"}, ce_n, e ? 0 : (we ? W + 2 : W));
    if (!e) begin
      check({tag, ".sram_addr"}, 32'(sram_addr), 32'(addr[19:2]));
      check({tag, ".be_l"}, 32'(be_seen), 32'(exp_be(sz, addr[1:0])));
    end
    if (!e && we) check({tag, ".bus"}, bus, exp_bus(sz, wd));
    if (e || !we) begin
      word = ref_mem[addr[9:2]];
      expd = 0;
      if (!e)
        for (int i = 0; i < nbytes(sz); i++) expd[8*i +: 8] = word[8*(lane_off(sz, addr[1:0]) + i) +: 8];
      check({tag, ".rdata"}, rdata, expd);
    end
    if (port == 1) m1_req = 0; else m0_req = 0;
    if (!e && we)
      for (int i = 0; i < nbytes(sz); i++)
        ref_mem[addr[9:2]][8*(lane_off(sz, addr[1:0]) + i) +: 8] = wd[8*i +: 8];
    ref_last = port;
  endtask

  // both ports request together; winner must be the port not granted last
  task automatic tie_round(input string tag);
    int   first, cnt;
    logic got, both;
    @(posedge clk); #1;
    m0_we = 0; m0_addr = 20'h20; m0_size = 2'd2; m0_req = 1;
    m1_we = 0; m1_addr = 20'h24; m1_size = 2'd2; m1_req = 1;
    first = -1; cnt = 0; got = 0; both = 0;
    while (!got && cnt < 40) begin
      @(negedge clk); cnt++;
      if (m0_ack && m1_ack) both = 1;
      if (m1_ack) begin first = 1; got = 1; m1_req = 0; end
      else if (m0_ack) begin first = 0; got = 1; m0_req = 0; end
    end
    check({tag, ".first_grant"}, first, 1 - ref_last);
    ref_last = first;
    cnt = 0; got = 0;
    while (!got && cnt < 40) begin
      @(negedge clk); cnt++;
      if (m0_ack && m1_ack) both = 1;
      if ((first == 1) ? m0_ack : m1_ack) got = 1;
    end
    check({tag, ".second_ack"}, 32'(got), 32'd1);
    check({tag, ".ack_overlap"}, 32'(both), 32'd0);
    m0_req = 0; m1_req = 0;
    ref_last = 1 - first;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ce_l"}, 32'(sram_ce_l), 32'd1);
    check({tag, ".oe_we_l"}, 32'({sram_oe_l, sram_we_l}), 32'd3);
    check({tag, ".be_l"}, 32'(sram_be_l), 32'hF);
    check({tag, ".acks_err"}, 32'({m0_ack, m1_ack, err}), 32'd0);
    check({tag, ".rdata"}, rdata, 32'd0);
    check({tag, ".sram_addr"}, 32'(sram_addr), 32'd0);
  endtask

  initial begin
    int   cnt;
    logic seen, acked;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1;

    tie_round("rr0");
    tie_round("rr1");

    access(0, 1, 20'h00010, 2'd2, 32'hDEADBEEF, "wr_deadbeef");
    access(1, 0, 20'h00010, 2'd2, 32'h0, "rd_word_0x10");
    access(0, 1, 20'h00003, 2'd0, 32'h0000005A, "wr_byte_5a");
    access(1, 0, 20'h00000, 2'd2, 32'h0, "rd_after_byte");
    access(1, 1, 20'h00000, 2'd2, 32'h12345678, "wr_12345678");
    access(0, 0, 20'h00002, 2'd1, 32'h0, "rd_half_hi");
    access(0, 0, 20'h00001, 2'd1, 32'h0, "rd_half_odd");
    access(1, 0, 20'h00008, 2'd3, 32'h0, "size_rsvd");
    access(0, 1, 20'h0000C, 2'd3, 32'hFFFFFFFF, "size_rsvd_wr");

    // reset in the middle of the write strobe
    @(posedge clk); #1;
    m0_we = 1; m0_addr = 20'h003C0; m0_size = 2'd2; m0_wdata = 32'hA5A5A5A5; m0_req = 1;
    cnt = 0; seen = 0;
    while (!seen && cnt < 40) begin @(negedge clk); cnt++; seen = !sram_we_l; end
    check("rst_mid.we_seen", 32'(seen), 32'd1);
    rst = 0; #1;
    check_reset_outputs("rst_mid");
    m0_req = 0; acked = 0;
    repeat (3) begin @(negedge clk); if (m0_ack || m1_ack) acked = 1; end
    check("rst_mid.no_ack", 32'(acked), 32'd0);
    rst = 1;
    ref_last = 0;
    access(1, 0, 20'h00000, 2'd2, 32'h0, "after_rst");

    for (int i = 0; i < 30; i++)
      access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 20'($urandom_range(0, 63)),
             2'($urandom_range(0, 3)), $urandom, $sformatf("rand%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
